debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel button debouncer, the successor to the single-channel debouncer. It sits between raw board push-button pins and the control logic. Each channel synchronises its input, rejects bounce with a symmetric press/release filter, and reports a stable level plus one-cycle press and release pulses. Auto-repeat pulses while a button is held can be compiled in.

## Interface
- `CHANNELS`, default 4: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, default 524287: consecutive stable cycles needed to accept a level change (≥1).
- `HOLD_CYCLES`, default 50000000: press-to-first-repeat delay in cycles (≥1). Used only with repeat enabled.
- `REPEAT_CYCLES`, default 10000000: period between later repeats (≥1). Used only with repeat enabled.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in CHANNELS: raw asynchronous button inputs, active-high.
- `level_out` out CHANNELS: debounced stable level.
- `press_pulse` out CHANNELS: one-cycle pulse on an accepted 0→1 change.
- `release_pulse` out CHANNELS: one-cycle pulse on an accepted 1→0 change.
- `repeat_pulse` out CHANNELS: one-cycle auto-repeat pulse.
- `any_press` out 1: OR of `press_pulse`, registered in the same cycle as the pulses.

## Operation
- Each channel has a 2-flop synchroniser (`sync1`, `sync2`), then an FSM with states IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT.
- The debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.
- IDLE (level 0):
  - `sync2`=1 → PRESS_WAIT with cnt=1.
- PRESS_WAIT:
  - `sync2`=0 → IDLE, cnt=0, no pulse.
  - Otherwise, cnt==DEBOUNCE_CYCLES → DOWN. Set `level_out`=1 and `press_pulse`=1.
  - Otherwise cnt+1.
- DOWN (level 1):
  - `sync2`=0 → RELEASE_WAIT with cnt=1.
- RELEASE_WAIT: mirrors PRESS_WAIT.
  - `sync2`=1 → DOWN, no pulse.
  - cnt==DEBOUNCE_CYCLES → IDLE. Set `level_out`=0 and `release_pulse`=1.
- A rejected glitch in either wait state produces no output change at all.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset behaviour:
  - Sync flops, counters and all outputs go to 0. The FSM goes to IDLE.
  - Reset mid-operation discards any pending change and emits no pulse.
  - A button still held after reset is re-accepted as a fresh press after the full latency.

## Timing
- All outputs are registered. Every output resets to 0.
- Latency is counted from the first clock edge at which `sync1` samples the new level (edge 1).
  - `sync2` changes at edge 2.
  - The wait state is entered at edge 3 with cnt=1.
  - `level_out` and the pulse change at edge DEBOUNCE_CYCLES+3.
- A pulse is high for exactly one cycle. `level_out` changes in the same cycle as its pulse.
- To be accepted, the input must hold the new level for DEBOUNCE_CYCLES+1 consecutive `sync2` samples.

## Configuration
- Macro `DEBOUNCE_REPEAT_EN` defined:
  - Each channel adds a hold counter of width `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)`. It clears to 0 on entry to DOWN and increments each cycle in DOWN.
  - First `repeat_pulse` fires HOLD_CYCLES cycles after `press_pulse`. The counter then clears and the next pulses fire every REPEAT_CYCLES cycles.
  - The counter freezes in RELEASE_WAIT. It resumes if the release glitch is rejected, and clears on an accepted release.
- Macro not defined:
  - No hold logic is built. `repeat_pulse` is tied to 0.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

## Structure
- Package `debounce_pkg` holds:
  - the state enum `db_state_t` (IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT);
  - a `clog2`-based width helper function.
- Sub-module `debounce_channel` is one synchroniser + FSM + counters. `debounce_bank` instantiates it CHANNELS times in a generate loop and registers `any_press`.

## Test plan
Bench parameters: CHANNELS=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Clean press: `btn_in[0]` goes 0→1 and stays high → `level_out[0]`=1 and `press_pulse[0]` and `any_press` high for one cycle at edge 7. No other channel responds.
- Bounce: `btn_in[1]` is high for 4 cycles, then low → no pulse and `level_out[1]` stays 0. Repeat with a 1-cycle low glitch during RELEASE_WAIT after a press → no `release_pulse`.
- Release: after the clean press, `btn_in[0]` goes 1→0 → `release_pulse[0]` at edge 7 relative to the release. `level_out[0]`=0 in the same cycle.
- Auto-repeat (macro on): hold `btn_in[2]`, press at edge 7 → `repeat_pulse[2]` at edges 27, 35, 43. With the macro off, `repeat_pulse` stays 0.
- Simultaneous: `btn_in[3:0]`=4'b1111 in one cycle → all four `press_pulse` bits high in the same cycle, `any_press` high once.
- Reset mid-operation: assert `rst` at edge 5 of a press → all outputs 0. Keep the button held and deassert `rst` → `press_pulse` 7 edges after the first post-reset sample.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the debounce_bank button debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      DOWN         = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   // Bits needed to hold any value in 0..max_val; never less than one bit.
   function automatic int cnt_width(input longint max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic longint max_of(input longint a, input longint b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, symmetric press/release filter,
// registered level/pulse outputs; hold/repeat timer only with DEBOUNCE_REPEAT_EN.
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   IDLE         | stable released, level_out = 0
//   PRESS_WAIT   | sync2 high, counting toward an accepted press
//   DOWN         | stable pressed, level_out = 1, hold timer runs
//   RELEASE_WAIT | sync2 low, counting toward an accepted release
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 524287,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse,
   output logic press_next
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   // Down-counter: loaded with the remaining stable samples, accept at zero.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   always_comb begin
      sync1_d   = btn_in;
      sync2_d   = sync1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         PRESS_WAIT: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = DOWN;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DOWN: begin
            if (!sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         RELEASE_WAIT: begin
            if (sync2_q) begin
               state_d = DOWN;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d   = IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int HOLD_W = cnt_width(max_of(HOLD_CYCLES, REPEAT_CYCLES));
   localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] REPEAT_LOAD = HOLD_W'(REPEAT_CYCLES - 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              repeat_q, repeat_d;

   // Timer keeps its value through RELEASE_WAIT so a rejected glitch resumes it.
   always_comb begin
      hold_d   = hold_q;
      repeat_d = 1'b0;
      if (press_d) begin
         hold_d = HOLD_LOAD;
      end else if (release_d) begin
         hold_d = '0;
      end else if (state_q == DOWN) begin
         if (hold_q == '0) begin
            repeat_d = 1'b1;
            hold_d   = REPEAT_LOAD;
         end else begin
            hold_d = hold_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q   <= '0;
         repeat_q <= 1'b0;
      end else begin
         hold_q   <= hold_d;
         repeat_q <= repeat_d;
      end
   end

   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign level_out     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign press_next    = press_d;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button debouncer: CHANNELS independent debounce_channel
// instances plus a registered any_press. Auto-repeat built with DEBOUNCE_REPEAT_EN.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 524287,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] repeat_pulse,
   output logic                any_press
);

   logic [CHANNELS-1:0] press_next;
   logic                any_press_q, any_press_d;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .btn_in        (btn_in[i]),
         .level_out     (level_out[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .repeat_pulse  (repeat_pulse[i]),
         .press_next    (press_next[i])
      );
   end

   // Built from the channels' next-state pulses so it lands with press_pulse.
   always_comb begin
      any_press_d = |press_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         any_press_q <= 1'b0;
      end else begin
         any_press_q <= any_press_d;
      end
   end

   assign any_press = any_press_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed edge-count checks plus randomized
// stimulus compared every cycle against a run-length reference model.
module tb_debounce_bank;

   localparam int CH = 4;
   localparam int D  = 4;
   localparam int H  = 20;
   localparam int R  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] btn_in = '0;
   logic [CH-1:0] level_out, press_pulse, release_pulse, repeat_pulse;
   logic          any_press;

   debounce_bank #(
      .CHANNELS        (CH),
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .level_out     (level_out),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .repeat_pulse  (repeat_pulse),
      .any_press     (any_press)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a level flips once D+1 consecutive synchronised samples
   // disagree with it; repeats count cycles spent stable-pressed.
   bit [CH-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;
   bit          m_any;
   bit          m_valid = 1'b0;
   int          m_run [CH];
   int          m_hc  [CH];
   bit          m_first [CH];

   always @(posedge clk) begin
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_level = '0;
         m_press = '0; m_rel = '0; m_rep = '0; m_any = 1'b0;
         for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_hc[c] = 0; m_first[c] = 1'b0;
         end
         m_valid = 1'b1;
      end else begin
         for (int c = 0; c < CH; c++) begin
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_rep[c]   = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            if (m_level[c] && m_run[c] == 0) begin
               m_hc[c]++;
               if (m_hc[c] == (m_first[c] ? H : R)) begin
                  m_rep[c]   = 1'b1;
                  m_hc[c]    = 0;
                  m_first[c] = 1'b0;
               end
            end
`endif
            if (m_s2[c] != m_level[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == D + 1) begin
               m_level[c] = ~m_level[c];
               m_run[c]   = 0;
               m_hc[c]    = 0;
               m_first[c] = 1'b1;
               if (m_level[c]) m_press[c] = 1'b1;
               else m_rel[c] = 1'b1;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_in[c];
         end
         m_any = |m_press;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("level_out",     level_out,     m_level);
         check("press_pulse",   press_pulse,   m_press);
         check("release_pulse", release_pulse, m_rel);
         check("repeat_pulse",  repeat_pulse,  m_rep);
         check("any_press",     any_press,     m_any);
      end
   end

   // Directed observation: edges counted from the first edge after a stimulus change.
   int press_edge, release_edge, allp_edge;
   int press_cnt, release_cnt, other_cnt, any_cnt;
   int rep_edges [$];

   task automatic watch(input int n, input int ch);
      press_edge = -1; release_edge = -1; allp_edge = -1;
      press_cnt = 0; release_cnt = 0; other_cnt = 0; any_cnt = 0;
      rep_edges.delete();
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         if (press_pulse[ch]) begin
            press_cnt++;
            if (press_edge < 0) press_edge = k;
         end
         if (release_pulse[ch]) begin
            release_cnt++;
            if (release_edge < 0) release_edge = k;
         end
         if (press_pulse == '1 && allp_edge < 0) allp_edge = k;
         for (int o = 0; o < CH; o++)
            if (o != ch && (press_pulse[o] || release_pulse[o])) other_cnt++;
         if (any_press) any_cnt++;
         if (repeat_pulse[ch]) rep_edges.push_back(k);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_level", level_out, 0);
      check("reset_any", any_press, 0);

      // Clean press on channel 0
      btn_in[0] = 1'b1;
      watch(12, 0);
      check("press_edge", press_edge, 7);
      check("press_count", press_cnt, 1);
      check("press_any_count", any_cnt, 1);
      check("press_others_quiet", other_cnt, 0);
      check("press_level", level_out[0], 1);

      // Clean release on channel 0
      @(negedge clk);
      btn_in[0] = 1'b0;
      watch(12, 0);
      check("release_edge", release_edge, 7);
      check("release_count", release_cnt, 1);
      check("release_level", level_out[0], 0);

      // 4-cycle bounce on channel 1 is one sample short of acceptance
      @(negedge clk);
      btn_in[1] = 1'b1;
      fork
         watch(14, 1);
         begin
            repeat (4) @(negedge clk);
            btn_in[1] = 1'b0;
         end
      join
      check("bounce_press_count", press_cnt, 0);
      check("bounce_level", level_out[1], 0);

      // 1-cycle low glitch while channel 1 is held
      @(negedge clk);
      btn_in[1] = 1'b1;
      watch(10, 1);
      check("glitch_setup_press", press_edge, 7);
      @(negedge clk);
      btn_in[1] = 1'b0;
      @(negedge clk);
      btn_in[1] = 1'b1;
      watch(16, 1);
      check("glitch_release_count", release_cnt, 0);
      check("glitch_level", level_out[1], 1);
      @(negedge clk);
      btn_in[1] = 1'b0;
      watch(10, 1);

      // Held channel 2: press then auto-repeat
      @(negedge clk);
      btn_in[2] = 1'b1;
      watch(45, 2);
      check("hold_press_edge", press_edge, 7);
`ifdef DEBOUNCE_REPEAT_EN
      check("repeat_count", rep_edges.size(), 3);
      if (rep_edges.size() == 3) begin
         check("repeat_edge_1", rep_edges[0], 27);
         check("repeat_edge_2", rep_edges[1], 35);
         check("repeat_edge_3", rep_edges[2], 43);
      end
`else
      check("repeat_count", rep_edges.size(), 0);
`endif
      @(negedge clk);
      btn_in[2] = 1'b0;
      watch(12, 2);

      // All four channels pressed together
      @(negedge clk);
      btn_in = 4'b1111;
      watch(10, 0);
      check("simul_all_edge", allp_edge, 7);
      check("simul_any_count", any_cnt, 1);
      check("simul_level", level_out, 4'b1111);
      @(negedge clk);
      btn_in = 4'b0000;
      watch(10, 0);

      // Reset at edge 5 of a press on channel 3; button stays held
      @(negedge clk);
      btn_in[3] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_level", level_out, 0);
      check("rst_press", press_pulse, 0);
      check("rst_release", release_pulse, 0);
      check("rst_repeat", repeat_pulse, 0);
      check("rst_any", any_press, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      watch(12, 3);
      check("post_rst_press_edge", press_edge, 7);
      check("post_rst_press_count", press_cnt, 1);

      // Randomized phase: bursts of chatter alternate with long holds
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 999) == 0);
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 99) < (((cyc / 500) % 2 == 0) ? 9 : 1))
               btn_in[c] = ~btn_in[c];
         end
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
